// File: rtl/alu_defs_pkg.sv
// Shared ALU interface definitions: widths, packed-command field positions and opcodes.
// Imported by the command FIFO, the sequencer top and the testbench.
package alu_defs;

    localparam int ALU_OP_W   = 3;
    localparam int ALU_DATA_W = 4;
    localparam int ALU_CMD_W  = ALU_OP_W + 2 * ALU_DATA_W;

    // Packed command layout: {opcode, in1, in2}
    localparam int CMD_IN2_LSB = 0;
    localparam int CMD_IN1_LSB = ALU_DATA_W;
    localparam int CMD_OP_LSB  = 2 * ALU_DATA_W;

    localparam logic [ALU_OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'd4;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'd5;
    localparam logic [ALU_OP_W-1:0] OP_SLLI = 3'd6;
    localparam logic [ALU_OP_W-1:0] OP_SRLI = 3'd7;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO for the ALU sequencer: push/pop, full/empty flags, head-of-queue view.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
    import alu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // NOTE: storage is not reset; the count/pointers define validity, so flushing only needs the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issuing side of the 4-bit ALU: queues packed commands, drives the ALU one command at a time and
// returns result/overflow in order. Optional overflow event counter under `ALU_SEQ_OVF_CNT_EN.
module alu_cmd_sequencer
    import alu_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = ALU_OP_W,
    parameter int DATA_W     = ALU_DATA_W
`ifdef ALU_SEQ_OVF_CNT_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_W+2*DATA_W-1:0] cmd_data,
    output logic [OP_W-1:0]        alu_opcode,
    output logic [DATA_W-1:0]      alu_in1,
    output logic [DATA_W-1:0]      alu_in2,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic                   alu_overflow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_ovf,
    output logic [OP_W-1:0]        rsp_op,
`ifdef ALU_SEQ_OVF_CNT_EN
    input  logic                   ovf_clr,
    output logic [CNT_W-1:0]       ovf_cnt,
`endif
    output logic                   busy,
    output logic                   ovf_sticky
);

    localparam int CMD_W = OP_W + 2 * DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic [OP_W-1:0]   r_alu_opcode;
    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_ovf;
    logic [OP_W-1:0]   r_rsp_op;
    logic              r_ovf_sticky;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_load;
    logic [CMD_W-1:0]  w_head;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    // The head is popped and loaded into the ALU operand registers in the same cycle.
    always_comb begin
        w_load = 1'b0;
        if (!w_empty) begin
            // NOTE: every always_comb output gets a default first so no path can infer a latch.
            w_load = (r_state == ST_IDLE) || (r_state == ST_RESP && rsp_ready);
        end
    end

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_din   (cmd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_opcode <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
        end else if (w_load) begin
            r_alu_opcode <= w_head[CMD_W-1 -: OP_W];
            r_alu_in1    <= w_head[2*DATA_W-1 -: DATA_W];
            r_alu_in2    <= w_head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_op     <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ALU has had a full cycle to settle on the registered operands.
                    r_rsp_data   <= alu_result;
                    r_rsp_ovf    <= alu_overflow;
                    r_rsp_op     <= r_alu_opcode;
                    r_rsp_valid  <= 1'b1;
                    r_ovf_sticky <= r_ovf_sticky | alu_overflow;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_load ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_OVF_CNT_EN
    logic [CNT_W-1:0] r_ovf_cnt;
    logic             w_ovf_event;

    assign w_ovf_event = (r_state == ST_ISSUE) && alu_overflow;

    // Clear has priority over a coincident increment; count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset || ovf_clr) begin
            r_ovf_cnt <= '0;
        end else if (w_ovf_event && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    assign alu_opcode = r_alu_opcode;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_op     = r_rsp_op;
    assign ovf_sticky = r_ovf_sticky;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule
